// File: rtl/riscv_instr_aligner.sv
`default_nettype none
// ============================================================================
// Module   : riscv_instr_aligner
// Purpose  : IF-stage instruction aligner. Takes word-aligned 32-bit fetch
//            words and presents one instruction per handshake, starting at
//            bit 0. The instruction is either a zero-extended 16-bit
//            compressed instruction or a full 32-bit instruction. A 32-bit
//            instruction may straddle two fetch words. Tracks the PC and
//            handles redirects to halfword-aligned targets.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   RESET_ADDR        PC after reset (word-aligned)
// Ports:
//   clk               clock
//   rst_n             synchronous active-low reset
//   branch_i          redirect strobe, flushes internal state
//   branch_addr_i     redirect target (bit 0 ignored)
//   fetch_valid_i     fetch word valid
//   fetch_rdata_i     fetch word
//   fetch_ready_o     fetch word consumed this cycle
//   instr_valid_o     aligned instruction valid
//   instr_ready_i     ID stage accepts the instruction
//   instr_aligned_o   aligned instruction
//   instr_addr_o      PC of instr_aligned_o
//   instr_is_c_o      instruction is compressed
//   misaligned_cnt_o  count of straddling 32-bit instructions
// Configuration macro:
//   RISCV_ALIGNER_PERF_EN  enables the saturating straddle counter;
//                          when undefined misaligned_cnt_o is tied to 0.
// ============================================================================
module riscv_instr_aligner #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_aligned_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_is_c_o,
  output logic [15:0] misaligned_cnt_o
);

  localparam logic [1:0] c_ALIGNED    = 2'd0;
  localparam logic [1:0] c_MISALIGNED = 2'd1;
  localparam logic [1:0] c_BRANCH_MIS = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_residue;
  logic [15:0] w_residue_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  logic        w_instr_hs;
  logic        w_word_is_c;
  logic        w_res_is_c;
  logic [31:0] w_branch_target;

  assign w_instr_hs      = instr_valid_o && instr_ready_i;
  assign w_word_is_c     = (fetch_rdata_i[1:0] != 2'b11);
  assign w_res_is_c      = (r_residue[1:0] != 2'b11);
  // Redirect targets are halfword-aligned; bit 0 is forced low.
  assign w_branch_target = branch_addr_i & ~32'h0000_0001;

  // --------------------------------------------------------------------------
  // State / datapath register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_ALIGNED;
      r_residue <= 16'h0000;
      r_pc      <= RESET_ADDR;
    end else begin
      r_state   <= w_state_next;
      r_residue <= w_residue_next;
      r_pc      <= w_pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_residue_next = r_residue;
    w_pc_next      = r_pc;

    if (branch_i) begin
      w_pc_next      = w_branch_target;
      w_residue_next = 16'h0000;
      w_state_next   = w_branch_target[1] ? c_BRANCH_MIS : c_ALIGNED;
    end else begin
      case (r_state)
        c_ALIGNED: begin
          if (w_instr_hs) begin
            if (w_word_is_c) begin
              // Upper halfword belongs to the next instruction.
              w_residue_next = fetch_rdata_i[31:16];
              w_pc_next      = r_pc + 32'd2;
              w_state_next   = c_MISALIGNED;
            end else begin
              w_pc_next      = r_pc + 32'd4;
            end
          end
        end
        c_MISALIGNED: begin
          if (w_instr_hs) begin
            if (w_res_is_c) begin
              w_pc_next      = r_pc + 32'd2;
              w_state_next   = c_ALIGNED;
            end else begin
              // Straddle: low half came from the residue, new residue is the
              // upper half of the word just consumed.
              w_residue_next = fetch_rdata_i[31:16];
              w_pc_next      = r_pc + 32'd4;
            end
          end
        end
        c_BRANCH_MIS: begin
          // Target sits in the upper halfword; the lower half is discarded.
          if (fetch_valid_i) begin
            w_residue_next = fetch_rdata_i[31:16];
            w_state_next   = c_MISALIGNED;
          end
        end
        default: begin
          w_state_next   = c_ALIGNED;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (combinational from registers and fetch inputs)
  // --------------------------------------------------------------------------
  always_comb begin
    instr_valid_o   = 1'b0;
    fetch_ready_o   = 1'b0;
    instr_aligned_o = 32'h0000_0000;

    if (!branch_i) begin
      case (r_state)
        c_ALIGNED: begin
          instr_valid_o   = fetch_valid_i;
          fetch_ready_o   = instr_ready_i;
          instr_aligned_o = w_word_is_c ? {16'h0000, fetch_rdata_i[15:0]}
                                        : fetch_rdata_i;
        end
        c_MISALIGNED: begin
          if (w_res_is_c) begin
            // Whole instruction already held; no fetch word needed.
            instr_valid_o   = 1'b1;
            instr_aligned_o = {16'h0000, r_residue};
          end else begin
            instr_valid_o   = fetch_valid_i;
            fetch_ready_o   = instr_ready_i;
            instr_aligned_o = {fetch_rdata_i[15:0], r_residue};
          end
        end
        c_BRANCH_MIS: begin
          fetch_ready_o   = 1'b1;
        end
        default: begin
          instr_valid_o   = 1'b0;
        end
      endcase
    end
  end

  assign instr_addr_o = r_pc;
  assign instr_is_c_o = (instr_aligned_o[1:0] != 2'b11);

  // --------------------------------------------------------------------------
  // Straddling-instruction counter
  // --------------------------------------------------------------------------
`ifdef RISCV_ALIGNER_PERF_EN
  logic [15:0] r_misaligned_cnt;
  logic        w_straddle_hs;

  assign w_straddle_hs = w_instr_hs && (r_state == c_MISALIGNED) && !w_res_is_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misaligned_cnt <= 16'h0000;
    end else if (w_straddle_hs && (r_misaligned_cnt != 16'hFFFF)) begin
      r_misaligned_cnt <= r_misaligned_cnt + 16'd1;
    end
  end

  assign misaligned_cnt_o = r_misaligned_cnt;
`else
  assign misaligned_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_instr_aligner
// Purpose  : Directed self-checking bench for riscv_instr_aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_aligner;

  logic        clk;
  logic        rst_n;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_aligned_o;
  logic [31:0] instr_addr_o;
  logic        instr_is_c_o;
  logic [15:0] misaligned_cnt_o;

  int checks = 0;
  int errors = 0;

`ifdef RISCV_ALIGNER_PERF_EN
  localparam logic [15:0] c_EXP_CNT1 = 16'd1;
`else
  localparam logic [15:0] c_EXP_CNT1 = 16'd0;
`endif

  riscv_instr_aligner #(.RESET_ADDR(32'h0000_0080)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_rdata_i   (fetch_rdata_i),
    .fetch_ready_o   (fetch_ready_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_aligned_o (instr_aligned_o),
    .instr_addr_o    (instr_addr_o),
    .instr_is_c_o    (instr_is_c_o),
    .misaligned_cnt_o(misaligned_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full instruction-side output set mid-cycle.
  task automatic chk_instr(input string tag, input logic vld, input logic [31:0] ins,
                           input logic [31:0] addr, input logic isc, input logic frdy);
    #2;
    chk({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, vld});
    if (vld) begin
      chk({tag, ".instr"}, instr_aligned_o, ins);
      chk({tag, ".is_c"},  {31'h0, instr_is_c_o}, {31'h0, isc});
    end
    chk({tag, ".addr"},  instr_addr_o, addr);
    chk({tag, ".fready"}, {31'h0, fetch_ready_o}, {31'h0, frdy});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; instr_ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; instr_ready_i = 1'b0;
    tick(); tick();

    // Reset state (still in reset)
    chk_instr("rst", 1'b0, 32'h0, 32'h80, 1'b0, 1'b0);
    chk("rst.cnt", {16'h0, misaligned_cnt_o}, 32'h0);
    rst_n = 1'b1;
    tick();
    // Out of reset, idle ALIGNED
    chk_instr("idle", 1'b0, 32'h0, 32'h80, 1'b0, 1'b0);

    // Two aligned 32-bit instructions
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00A00093;
    chk_instr("w32a", 1'b1, 32'h00A00093, 32'h80, 1'b0, 1'b1);
    tick();
    fetch_rdata_i = 32'h00108113;
    chk_instr("w32b", 1'b1, 32'h00108113, 32'h84, 1'b0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("w32end", 1'b0, 32'h0, 32'h88, 1'b0, 1'b1);

    // Two compressed in one word
    do_reset();
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h45014501;
    chk_instr("cc0", 1'b1, 32'h00004501, 32'h80, 1'b1, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("cc1", 1'b1, 32'h00004501, 32'h82, 1'b1, 1'b0);
    tick();
    chk_instr("cc_al", 1'b0, 32'h0, 32'h84, 1'b0, 1'b1);

    // Compressed, straddling 32-bit, compressed
    do_reset();
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00934505;
    chk_instr("st0", 1'b1, 32'h00004505, 32'h80, 1'b1, 1'b1);
    tick();
    fetch_rdata_i = 32'h450100A0;
    chk_instr("st1", 1'b1, 32'h00A00093, 32'h82, 1'b0, 1'b1);
    chk("st1.cnt", {16'h0, misaligned_cnt_o}, 32'h0);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("st2", 1'b1, 32'h00004501, 32'h86, 1'b1, 1'b0);
    chk("st2.cnt", {16'h0, misaligned_cnt_o}, {16'h0, c_EXP_CNT1});
    tick();
    chk_instr("st_al", 1'b0, 32'h0, 32'h88, 1'b0, 1'b1);

    // Branch to halfword-misaligned target
    branch_i = 1'b1; branch_addr_i = 32'h00000103; fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00A00093;
    chk_instr("br", 1'b0, 32'h0, 32'h88, 1'b0, 1'b0);
    tick();
    branch_i = 1'b0; fetch_rdata_i = 32'h4505ABCD;
    chk_instr("brmis", 1'b0, 32'h0, 32'h102, 1'b0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("brtgt", 1'b1, 32'h00004505, 32'h102, 1'b1, 1'b0);
    tick();
    chk_instr("brnext", 1'b0, 32'h0, 32'h104, 1'b0, 1'b1);

    // PC wrap-around
    branch_i = 1'b1; branch_addr_i = 32'hFFFFFFFC;
    tick();
    branch_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00000013;
    chk_instr("wrap0", 1'b1, 32'h00000013, 32'hFFFFFFFC, 1'b0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("wrap1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // ID stall in the middle of a straddle
    do_reset();
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00934505;
    tick();
    fetch_rdata_i = 32'h450100A0; instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_instr("stall", 1'b1, 32'h00A00093, 32'h82, 1'b0, 1'b0);
      tick();
    end
    instr_ready_i = 1'b1;
    chk_instr("rel", 1'b1, 32'h00A00093, 32'h82, 1'b0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk_instr("rel_next", 1'b1, 32'h00004501, 32'h86, 1'b1, 1'b0);

    // Branch with residue pending and fetch valid: residue flushed
    branch_i = 1'b1; branch_addr_i = 32'h00000200; fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00000013;
    chk_instr("brflush", 1'b0, 32'h0, 32'h86, 1'b0, 1'b0);
    tick();
    branch_i = 1'b0; fetch_valid_i = 1'b0;
    chk_instr("postbr", 1'b0, 32'h0, 32'h200, 1'b0, 1'b1);

    // Reset mid-stream overrides a simultaneous branch
    branch_i = 1'b1; branch_addr_i = 32'h00000302; fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h45014501; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; branch_i = 1'b0; fetch_valid_i = 1'b0;
    chk_instr("rst2", 1'b0, 32'h0, 32'h80, 1'b0, 1'b1);
    chk("rst2.cnt", {16'h0, misaligned_cnt_o}, 32'h0);
    fetch_valid_i = 1'b1; fetch_rdata_i = 32'h00108113;
    chk_instr("rst2.first", 1'b1, 32'h00108113, 32'h80, 1'b0, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
